// File: rtl/eth_pkg.sv
// Shared constants and state types for the Ethernet AXI4-Lite register bank.
package eth_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned STS_IDX_DEF = 8;
  localparam int unsigned STS_W       = 32;

  // Status bit positions driven by the datapath event sources
  localparam int unsigned STS_BIT_RX_CRC_ERR = 0;
  localparam int unsigned STS_BIT_RX_OVF     = 1;
  localparam int unsigned STS_BIT_TX_UNF     = 2;
  localparam int unsigned STS_BIT_LINK_CHG   = 3;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_HOLD = 2'd1,
    WR_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/eth_sts_reg.sv
// Sticky status register: events set bits, W1C and clear-on-read clear them; set wins.
module eth_sts_reg
  import eth_pkg::*;
#(
  parameter int unsigned W = STS_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_set,
  input  logic         i_w1c_en,
  input  logic [W-1:0] i_w1c_data,
  input  logic         i_rdclr,
  output logic [W-1:0] o_sts
);

  logic [W-1:0] r_sts;
  logic [W-1:0] w_clr;

  assign w_clr = (i_w1c_en ? i_w1c_data : '0) | {W{i_rdclr}};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sts <= '0;
    else          r_sts <= (r_sts & ~w_clr) | i_set;
  end

  assign o_sts = r_sts;

endmodule

// File: rtl/eth_axil_regs.sv
// AXI4-Lite register bank: NUM_REGS RW control words plus one sticky status word.
// Define ETH_REGS_RDCLR_EN to make an OKAY read of the status word clear it.
module eth_axil_regs
  import eth_pkg::*;
#(
  parameter int unsigned S_AXI_ADDR_WIDTH = 11,
  parameter int unsigned S_AXI_DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS         = 8,
  parameter int unsigned STS_IDX          = STS_IDX_DEF
) (
  input  logic                                 s_axi_aclk,
  input  logic                                 s_axi_aresetn,
  input  logic [S_AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
  input  logic                                 s_axi_awvalid,
  output logic                                 s_axi_awready,
  input  logic [S_AXI_DATA_WIDTH-1:0]          s_axi_wdata,
  input  logic                                 s_axi_wvalid,
  output logic                                 s_axi_wready,
  output logic [1:0]                           s_axi_bresp,
  output logic                                 s_axi_bvalid,
  input  logic                                 s_axi_bready,
  input  logic [S_AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
  input  logic                                 s_axi_arvalid,
  output logic                                 s_axi_arready,
  output logic [S_AXI_DATA_WIDTH-1:0]          s_axi_rdata,
  output logic [1:0]                           s_axi_rresp,
  output logic                                 s_axi_rvalid,
  input  logic                                 s_axi_rready,
  output logic [NUM_REGS*S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]                  reg_wr_stb,
  input  logic [S_AXI_DATA_WIDTH-1:0]          sts_evt
);

  localparam int unsigned DW   = S_AXI_DATA_WIDTH;
  localparam int unsigned IDXW = S_AXI_ADDR_WIDTH - 2;

  wr_state_e         r_wr_state;
  rd_state_e         r_rd_state;
  logic              r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic              r_aw_full, r_w_full;
  logic [1:0]        r_bresp, r_rresp;
  logic [IDXW-1:0]   r_aw_idx;
  logic [DW-1:0]     r_wdata, r_rdata;
  logic [DW-1:0]     r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_wr_stb;

  logic            w_aw_hs, w_w_hs, w_ar_hs;
  logic            w_wr_reg, w_wr_sts, w_rd_ok, w_rdclr;
  logic [IDXW-1:0] w_ar_idx;
  logic [DW-1:0]   w_rd_data, w_sts;
  logic            w_unused_addr_lsb;

  assign w_unused_addr_lsb = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign w_aw_hs  = s_axi_awvalid & r_awready;
  assign w_w_hs   = s_axi_wvalid & r_wready;
  assign w_ar_hs  = s_axi_arvalid & r_arready;
  assign w_ar_idx = s_axi_araddr[S_AXI_ADDR_WIDTH-1:2];

  // Commit happens in HOLD, the cycle after both AW and W are buffered
  assign w_wr_reg = (r_wr_state == WR_HOLD) && (32'(r_aw_idx) < NUM_REGS);
  assign w_wr_sts = (r_wr_state == WR_HOLD) && (r_aw_idx == IDXW'(STS_IDX));

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_wr_state <= WR_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_aw_full  <= 1'b0;
      r_w_full   <= 1'b0;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_stb   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_stb <= '0;
      case (r_wr_state)
        WR_IDLE: begin
          if (w_aw_hs) begin
            r_aw_full <= 1'b1;
            r_aw_idx  <= s_axi_awaddr[S_AXI_ADDR_WIDTH-1:2];
            r_awready <= 1'b0;
          end else if (!r_aw_full) begin
            r_awready <= 1'b1;
          end
          if (w_w_hs) begin
            r_w_full <= 1'b1;
            r_wdata  <= s_axi_wdata;
            r_wready <= 1'b0;
          end else if (!r_w_full) begin
            r_wready <= 1'b1;
          end
          if ((r_aw_full | w_aw_hs) && (r_w_full | w_w_hs)) r_wr_state <= WR_HOLD;
        end
        WR_HOLD: begin
          r_bvalid   <= 1'b1;
          r_bresp    <= (w_wr_reg || w_wr_sts) ? RESP_OKAY : RESP_SLVERR;
          r_wr_state <= WR_RESP;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (w_wr_reg && (r_aw_idx == IDXW'(i))) begin
              r_regs[i]   <= r_wdata;
              r_wr_stb[i] <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            r_bvalid   <= 1'b0;
            r_aw_full  <= 1'b0;
            r_w_full   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // Read decode on the live AR address; registered on the handshake
  always_comb begin
    w_rd_data = '0;
    w_rd_ok   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_ar_idx == IDXW'(i)) begin
        w_rd_data = r_regs[i];
        w_rd_ok   = 1'b1;
      end
    end
    if (w_ar_idx == IDXW'(STS_IDX)) begin
      w_rd_data = w_sts;
      w_rd_ok   = 1'b1;
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_rdata    <= w_rd_data;
            r_rresp    <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_rvalid   <= 1'b1;
            r_arready  <= 1'b0;
            r_rd_state <= RD_RESP;
          end else begin
            r_arready <= 1'b1;
          end
        end
        RD_RESP: begin
          if (s_axi_rready) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

`ifdef ETH_REGS_RDCLR_EN
  assign w_rdclr = w_ar_hs && (w_ar_idx == IDXW'(STS_IDX));
`else
  assign w_rdclr = 1'b0;
`endif

  eth_sts_reg #(.W(DW)) u_sts (
    .i_clk      (s_axi_aclk),
    .i_rst_n    (s_axi_aresetn),
    .i_set      (sts_evt),
    .i_w1c_en   (w_wr_sts),
    .i_w1c_data (r_wdata),
    .i_rdclr    (w_rdclr),
    .o_sts      (w_sts)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DW +: DW] = r_regs[g];
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign reg_wr_stb    = r_wr_stb;

endmodule
